// File: rtl/demux1t8_4_seq.sv
// Registered 1-to-8 demux and frame assembler.
// Fills eight held channels and pulses frame_done when all are written.
module demux1t8_4_seq #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic [2:0]   sel,
  input  logic         wr,
  input  logic         auto,
  input  logic         clr,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [W-1:0] o4,
  output logic [W-1:0] o5,
  output logic [W-1:0] o6,
  output logic [W-1:0] o7,
  output logic [2:0]   ptr,
  output logic [7:0]   upd,
  output logic         frame_done
);

  logic [W-1:0] r_bank [8];
  logic [2:0]   r_ptr;
  logic [7:0]   r_upd;
  logic         r_done;

  logic [2:0]   w_tgt;
  logic [7:0]   w_upd_nxt;
  logic         w_full;

  assign w_tgt     = auto ? r_ptr : sel;
  assign w_upd_nxt = r_upd | (8'(1) << w_tgt);
  assign w_full    = (w_upd_nxt == 8'hFF);

  // rst and clr share one clear path; rst only wins by being first
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 8; i++) begin
        r_bank[i] <= RST_VAL;
      end
      r_ptr  <= '0;
      r_upd  <= '0;
      r_done <= 1'b0;
    end else if (wr) begin
      r_bank[w_tgt] <= din;
      if (auto) begin
        r_ptr <= r_ptr + 3'd1;
      end
      if (w_full) begin
        r_upd  <= '0;
        r_done <= 1'b1;
      end else begin
        r_upd  <= w_upd_nxt;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o0         = r_bank[0];
  assign o1         = r_bank[1];
  assign o2         = r_bank[2];
  assign o3         = r_bank[3];
  assign o4         = r_bank[4];
  assign o5         = r_bank[5];
  assign o6         = r_bank[6];
  assign o7         = r_bank[7];
  assign ptr        = r_ptr;
  assign upd        = r_upd;
  assign frame_done = r_done;

endmodule
